// File: rtl/rc4_xor_stream.sv
// RC4 keystream consumer: buffers keystream bytes in a small FIFO and XORs each
// with one data byte per message of programmable length, on a registered output.
module rc4_xor_stream #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LEN_W-1:0]              msg_len,
    input  logic                          clear,
    input  logic                          ks_valid,
    input  logic [7:0]                    ks_data,
    output logic                          ks_ready,
    input  logic                          din_valid,
    input  logic [7:0]                    din_data,
    output logic                          din_ready,
    output logic                          dout_valid,
    output logic [7:0]                    dout_data,
    output logic                          dout_last,
    input  logic                          dout_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          ks_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   ks_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             r_overflow;
    logic             r_last_issued;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic             r_dout_valid;
    logic [7:0]       r_dout_data;
    logic             r_dout_last;

    logic             w_ks_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_start_ok;

    // ks_ready looks only at the registered level, so a full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign w_ks_ready = (r_level != (AW+1)'(FIFO_DEPTH));
    assign w_push     = ks_valid & w_ks_ready & ~clear;
    assign din_ready  = (r_state == S_RUN) & (r_level != '0) &
                        (~r_dout_valid | dout_ready) & ~r_last_issued;
    assign w_pop      = din_valid & din_ready;
    assign w_start_ok = start & (r_state != S_RUN);

    assign ks_ready    = w_ks_ready;
    assign ks_level    = r_level;
    assign ks_overflow = r_overflow;
    assign dout_valid  = r_dout_valid;
    assign dout_data   = r_dout_data;
    assign dout_last   = r_dout_last;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= ks_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + (AW+1)'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - (AW+1)'(1);
            if (ks_valid && !w_ks_ready)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_count       <= '0;
            r_last_issued <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_dout_data   <= '0;
            r_dout_last   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_dout_valid <= 1'b1;
                r_dout_data  <= din_data ^ r_mem[r_rptr];
                r_dout_last  <= (r_count == r_len - LEN_W'(1));
                r_count      <= r_count + LEN_W'(1);
                if (r_count == r_len - LEN_W'(1))
                    r_last_issued <= 1'b1;
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            case (r_state)
                S_RUN: begin
                    if (r_dout_valid && dout_ready && r_dout_last)
                        r_state <= S_DONE;
                end
                default: begin
                    if (w_start_ok) begin
                        r_len         <= msg_len;
                        r_count       <= '0;
                        r_last_issued <= 1'b0;
                        r_state       <= (msg_len != '0) ? S_RUN : S_DONE;
                    end
                end
            endcase
        end
    end

endmodule
